// File: rtl/fifo_umbral_if.sv
// rtl/fifo_umbral_if.sv - FIFO port bundle with master/slave modports
// Carries thresholds, push/pop handshake, data and status flags.
interface fifo_umbral_if #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2
);
  logic              init;
  logic [ADDR_W-1:0] af_thr_i;
  logic [ADDR_W-1:0] ae_thr_i;
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              error;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   max_count;

  modport master (
    output init, af_thr_i, ae_thr_i, push, data_in, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty,
           error, count, max_count
  );

  modport slave (
    input  init, af_thr_i, ae_thr_i, push, data_in, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty,
           error, count, max_count
  );
endinterface

// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - synchronous FIFO with programmable almost-full/empty thresholds
// Optional peak-occupancy tracking enabled by macro FIFO_UMBRAL_STATS_EN.
module fifo_umbral #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2,
  parameter int AF_DEF = 3,
  parameter int AE_DEF = 1
) (
  input logic          clk,
  input logic          reset,
  fifo_umbral_if.slave bus
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] AF_RST = ADDR_W'(AF_DEF);
  localparam logic [ADDR_W-1:0] AE_RST = ADDR_W'(AE_DEF);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] af_q, af_d;
  logic [ADDR_W-1:0] ae_q, ae_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afl_q, afl_d;
  logic              ael_q, ael_d;
  logic              err_q, err_d;
  logic              push_ok, pop_ok;

  always_comb begin
    pop_ok  = bus.pop && (count_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    push_ok = bus.push && ((count_q != DEPTH_C) || pop_ok);

    wr_ptr_d = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    dout_d  = pop_ok ? mem_q[rd_ptr_q] : dout_q;
    valid_d = pop_ok;
    err_d   = err_q | (bus.push & ~push_ok) | (bus.pop & (count_q == '0));

    af_d = bus.init ? bus.af_thr_i : af_q;
    ae_d = bus.init ? bus.ae_thr_i : ae_q;

    // Flags use the thresholds held before this edge's load.
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    afl_d   = (af_q != '0) && (count_d >= {1'b0, af_q});
    ael_d   = (count_d <= {1'b0, ae_q});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      af_q     <= AF_RST;
      ae_q     <= AE_RST;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      // Count 0 can never reach a nonzero af threshold, and is always <= ae.
      afl_q    <= 1'b0;
      ael_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afl_q    <= afl_d;
      ael_q    <= ael_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

`ifdef FIFO_UMBRAL_STATS_EN
  logic [ADDR_W:0] max_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      max_q <= '0;
    end else if (count_d > max_q) begin
      max_q <= count_d;
    end
  end

  assign bus.max_count = max_q;
`else
  assign bus.max_count = '0;
`endif

  assign bus.data_out     = dout_q;
  assign bus.valid_out    = valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afl_q;
  assign bus.almost_empty = ael_q;
  assign bus.error        = err_q;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// tb/tb_fifo_umbral.sv - directed table plus randomized queue-model bench for fifo_umbral
// Expected peak occupancy follows macro FIFO_UMBRAL_STATS_EN.
module tb_fifo_umbral;

  localparam int DATA_W = 6;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int AF_DEF = 3;
  localparam int AE_DEF = 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fifo_umbral_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fifo_umbral #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_DEF(AF_DEF), .AE_DEF(AE_DEF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int rst, init, af, ae, push, pop, din;
    int cnt, full, empty, afl, ael, err, vld, dout;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural reference: a queue of stored words plus observable state.
  int mq[$];
  int m_err, m_vld, m_dout, m_af, m_ae, m_afl, m_ael, m_peak;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(int rst, int init, int af, int ae, int push, int pop, int din);
    int cnt, oaf, oae, pop_ok, push_ok;
    if (rst != 0) begin
      mq.delete();
      m_err = 0; m_vld = 0; m_dout = 0; m_peak = 0;
      m_af = AF_DEF; m_ae = AE_DEF;
      m_afl = 0; m_ael = 1;
    end else begin
      oaf = m_af;
      oae = m_ae;
      cnt = mq.size();
      pop_ok  = (pop != 0 && cnt > 0) ? 1 : 0;
      push_ok = (push != 0 && (cnt < DEPTH || pop_ok != 0)) ? 1 : 0;
      if ((push != 0 && push_ok == 0) || (pop != 0 && cnt == 0)) m_err = 1;
      m_vld = pop_ok;
      if (pop_ok != 0) m_dout = mq.pop_front();
      if (push_ok != 0) mq.push_back(din);
      if (init != 0) begin
        m_af = af;
        m_ae = ae;
      end
      if (mq.size() > m_peak) m_peak = mq.size();
      m_afl = (oaf != 0 && mq.size() >= oaf) ? 1 : 0;
      m_ael = (mq.size() <= oae) ? 1 : 0;
    end
  endtask

  function automatic int exp_max();
`ifdef FIFO_UMBRAL_STATS_EN
    return m_peak;
`else
    return 0;
`endif
  endfunction

  task automatic step(int rst, int init, int af, int ae, int push, int pop, int din);
    reset        = (rst != 0);
    bus.init     = (init != 0);
    bus.af_thr_i = ADDR_W'(af);
    bus.ae_thr_i = ADDR_W'(ae);
    bus.push     = (push != 0);
    bus.pop      = (pop != 0);
    bus.data_in  = DATA_W'(din);
    @(posedge clk);
    model_edge(rst, init, af, ae, push, pop, din);
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, " count"},     int'(bus.count),        mq.size());
    chk({tag, " full"},      int'(bus.full),         (mq.size() == DEPTH) ? 1 : 0);
    chk({tag, " empty"},     int'(bus.empty),        (mq.size() == 0) ? 1 : 0);
    chk({tag, " afull"},     int'(bus.almost_full),  m_afl);
    chk({tag, " aempty"},    int'(bus.almost_empty), m_ael);
    chk({tag, " error"},     int'(bus.error),        m_err);
    chk({tag, " valid"},     int'(bus.valid_out),    m_vld);
    chk({tag, " data_out"},  int'(bus.data_out),     m_dout);
    chk({tag, " max_count"}, int'(bus.max_count),    exp_max());
  endtask

  initial begin
    int pprob, qprob;
    reset = 1'b1;
    bus.init = 1'b0; bus.af_thr_i = '0; bus.ae_thr_i = '0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;

    //              rst ini af ae psh pop din    cnt ful emp afl ael err vld dout
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0,       0, 0, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0,       0, 0, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 'h11,    1, 0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 'h22,    2, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 'h33,    3, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 'h04,    4, 1, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 'h3F,    4, 1, 0, 1, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 0,       3, 0, 0, 1, 0, 1, 1, 'h11});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 0,       2, 0, 0, 0, 0, 1, 1, 'h22});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 0,       1, 0, 0, 0, 1, 1, 1, 'h33});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 0,       0, 0, 1, 0, 1, 1, 1, 'h04});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0,       0, 0, 1, 0, 1, 1, 0, 'h04});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0,       0, 0, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 1, 'h05,    1, 0, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0,       0, 0, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 0,       0, 0, 1, 0, 1, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0,       0, 0, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 'h01,    1, 0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 'h02,    2, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 1, 'h10,    2, 0, 0, 0, 0, 0, 1, 'h01});
    vecs.push_back('{0, 0, 0, 0, 1, 1, 'h11,    2, 0, 0, 0, 0, 0, 1, 'h02});
    vecs.push_back('{0, 0, 0, 0, 1, 1, 'h12,    2, 0, 0, 0, 0, 0, 1, 'h10});
    vecs.push_back('{0, 0, 0, 0, 1, 1, 'h13,    2, 0, 0, 0, 0, 0, 1, 'h11});
    vecs.push_back('{0, 0, 0, 0, 1, 1, 'h14,    2, 0, 0, 0, 0, 0, 1, 'h12});
    vecs.push_back('{0, 0, 0, 0, 1, 1, 'h15,    2, 0, 0, 0, 0, 0, 1, 'h13});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 'h16,    3, 0, 0, 1, 0, 0, 0, 'h13});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 'h17,    4, 1, 0, 1, 0, 0, 0, 'h13});
    vecs.push_back('{0, 0, 0, 0, 1, 1, 'h18,    4, 1, 0, 1, 0, 0, 1, 'h14});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 0,       3, 0, 0, 1, 0, 0, 1, 'h15});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 0,       2, 0, 0, 0, 0, 0, 1, 'h16});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 0,       1, 0, 0, 0, 1, 0, 1, 'h17});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 0,       0, 0, 1, 0, 1, 0, 1, 'h18});
    vecs.push_back('{0, 1, 2, 0, 0, 0, 0,       0, 0, 1, 0, 1, 0, 0, 'h18});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 'h21,    1, 0, 0, 0, 0, 0, 0, 'h18});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 'h22,    2, 0, 0, 1, 0, 0, 0, 'h18});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 0,       2, 0, 0, 1, 0, 0, 0, 'h18});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0,       2, 0, 0, 0, 0, 0, 0, 'h18});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 'h23,    3, 0, 0, 0, 0, 0, 0, 'h18});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 'h24,    4, 1, 0, 0, 0, 0, 0, 'h18});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].init, vecs[i].af, vecs[i].ae,
           vecs[i].push, vecs[i].pop, vecs[i].din);
      chk($sformatf("row%0d count", i),  int'(bus.count),        vecs[i].cnt);
      chk($sformatf("row%0d full", i),   int'(bus.full),         vecs[i].full);
      chk($sformatf("row%0d empty", i),  int'(bus.empty),        vecs[i].empty);
      chk($sformatf("row%0d afull", i),  int'(bus.almost_full),  vecs[i].afl);
      chk($sformatf("row%0d aempty", i), int'(bus.almost_empty), vecs[i].ael);
      chk($sformatf("row%0d error", i),  int'(bus.error),        vecs[i].err);
      chk($sformatf("row%0d valid", i),  int'(bus.valid_out),    vecs[i].vld);
      chk($sformatf("row%0d dout", i),   int'(bus.data_out),     vecs[i].dout);
      chk($sformatf("row%0d max", i),    int'(bus.max_count),    exp_max());
    end

    // Peak occupancy after a full fill, and retained through a drain.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 0, 8 + k);
`ifdef FIFO_UMBRAL_STATS_EN
    chk("peak after fill", int'(bus.max_count), 4);
`else
    chk("peak after fill", int'(bus.max_count), 0);
`endif
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      chk($sformatf("drain word %0d", k), int'(bus.data_out), 8 + k);
    end
`ifdef FIFO_UMBRAL_STATS_EN
    chk("peak after drain", int'(bus.max_count), 4);
`else
    chk("peak after drain", int'(bus.max_count), 0);
`endif
    chk("empty after drain", int'(bus.empty), 1);

    // Randomized traffic with shifting push/pop bias to visit full and empty.
    step(1, 0, 0, 0, 0, 0, 0);
    check_model("rand reset");
    pprob = 50;
    qprob = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) begin
        pprob = $urandom_range(10, 90);
        qprob = $urandom_range(10, 90);
      end
      step(($urandom_range(0, 299) == 0) ? 1 : 0,
           ($urandom_range(0, 19) == 0) ? 1 : 0,
           $urandom_range(0, 3), $urandom_range(0, 3),
           ($urandom_range(0, 99) < pprob) ? 1 : 0,
           ($urandom_range(0, 99) < qprob) ? 1 : 0,
           $urandom_range(0, 63));
      check_model($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
